// File: rtl/branch_predictor_if.sv
// Fetch/execute-side signal bundle for the branch predictor.
// master: pipeline side (drives fetch PC and execute resolution).
// slave : predictor side (drives prediction, redirect and flushes).
interface branch_predictor_if;
    // Fetch-side lookup
    logic [31:0] PCF;
    logic        BP;
    logic [31:0] PredPCF;

    // Execute-side resolution
    logic        BranchE;
    logic        TakenE;
    logic        BPE;
    logic        StallE;
    logic [31:0] PCE;
    logic [31:0] PCPlus4E;
    logic [31:0] PCTargetE;

    // Misprediction recovery
    logic        MispredictE;
    logic [31:0] RedirectPCE;
    logic        FlushD;
    logic        FlushE;

    modport master (
        output PCF, BranchE, TakenE, BPE, StallE, PCE, PCPlus4E, PCTargetE,
        input  BP, PredPCF, MispredictE, RedirectPCE, FlushD, FlushE
    );

    modport slave (
        input  PCF, BranchE, TakenE, BPE, StallE, PCE, PCPlus4E, PCTargetE,
        output BP, PredPCF, MispredictE, RedirectPCE, FlushD, FlushE
    );
endinterface

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB plus 2-bit saturating counters.
// Lookup is combinational on PCF; tables update one edge after a non-stalled
// execute-stage resolution. Misprediction redirect and flushes are
// combinational in the execute cycle.
// Optional feature macro: BP_GSHARE_EN -- when defined, a global history
// register is XORed into the counter index (gshare); the BTB stays indexed
// by the raw PC. When undefined the predictor is plain bimodal.
module branch_predictor #(
    parameter int IDX_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    branch_predictor_if.slave bus
);

    localparam int N     = 1 << IDX_W;
    localparam int TAG_W = 32 - IDX_W - 2;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [TAG_W-1:0] tag_t;

    // Prediction tables
    logic        valid_q  [N];
    logic [1:0]  cnt_q    [N];
    tag_t        tag_q    [N];
    logic [31:0] target_q [N];

    // Fetch-side lookup
    idx_t        btb_idx_f;
    idx_t        cnt_idx_f;
    tag_t        tag_f;
    logic        hit_f;

    // Execute-side update
    idx_t        btb_idx_e;
    idx_t        cnt_idx_e;
    tag_t        tag_e;
    logic        resolve_e;
    logic        alloc_e;
    logic [1:0]  cnt_e;
    logic [1:0]  cnt_d;

`ifdef BP_GSHARE_EN
    idx_t        ghr_q;
    idx_t        ghr_d;
`endif

    // The two low PC bits are always zero for aligned instructions.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.PCF[1:0], bus.PCE[1:0]};

    // Split fetch and execute PCs into index/tag; hash the counter index.
    // NOTE: every variable written in an always_comb gets a value on every
    // path (here unconditionally) so no latch can be inferred.
    always_comb begin
        btb_idx_f = bus.PCF[IDX_W+1:2];
        tag_f     = bus.PCF[31:IDX_W+2];
        btb_idx_e = bus.PCE[IDX_W+1:2];
        tag_e     = bus.PCE[31:IDX_W+2];
`ifdef BP_GSHARE_EN
        cnt_idx_f = btb_idx_f ^ ghr_q;
        cnt_idx_e = btb_idx_e ^ ghr_q;
`else
        cnt_idx_f = btb_idx_f;
        cnt_idx_e = btb_idx_e;
`endif
    end

    // Combinational lookup: predict taken only on a tag hit with counter MSB set.
    always_comb begin
        hit_f       = valid_q[btb_idx_f] && (tag_q[btb_idx_f] == tag_f);
        bus.BP      = hit_f && cnt_q[cnt_idx_f][1];
        bus.PredPCF = hit_f ? target_q[btb_idx_f] : 32'h0;
    end

    // Resolution: saturating counter step and BTB allocation on taken.
    always_comb begin
        resolve_e = bus.BranchE && !bus.StallE;
        alloc_e   = resolve_e && bus.TakenE;
        cnt_e     = cnt_q[cnt_idx_e];
        cnt_d     = cnt_e;
        if (bus.TakenE) begin
            if (cnt_e != 2'b11) begin
                cnt_d = cnt_e + 2'd1;
            end
        end else begin
            if (cnt_e != 2'b00) begin
                cnt_d = cnt_e - 2'd1;
            end
        end
    end

    // Misprediction detection and recovery target; silent while stalled or in reset.
    always_comb begin
        bus.MispredictE = !reset && !bus.StallE &&
                          ((bus.BranchE && (bus.BPE ^ bus.TakenE)) ||
                           (!bus.BranchE && bus.BPE));
        bus.RedirectPCE = (bus.BranchE && bus.TakenE) ? bus.PCTargetE : bus.PCPlus4E;
        bus.FlushD      = bus.MispredictE;
        bus.FlushE      = bus.MispredictE;
    end

    // Valid bits and counters: cleared/initialised on reset, written on resolution.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; this is also what makes a same-cycle lookup of the entry
    // being updated return the old contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= 2'b01;
            end
        end else if (resolve_e) begin
            cnt_q[cnt_idx_e] <= cnt_d;
            if (bus.TakenE) begin
                valid_q[btb_idx_e] <= 1'b1;
            end
        end
    end

    // BTB tag/target storage, written on taken resolutions only.
    // NOTE: tag and target arrays are deliberately not reset: they are never
    // observed until the matching valid bit is set, so they can map to plain RAM.
    always_ff @(posedge clk) begin
        if (alloc_e) begin
            tag_q[btb_idx_e]    <= tag_e;
            target_q[btb_idx_e] <= bus.PCTargetE;
        end
    end

`ifdef BP_GSHARE_EN
    // Global history: shift in each resolved direction, non-speculatively.
    always_comb begin
        ghr_d = resolve_e ? {ghr_q[IDX_W-2:0], bus.TakenE} : ghr_q;
    end

    // History register with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end
`endif

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-side dynamic branch predictor for the pipelined core. It looks up the fetch PC in a direct-mapped branch target buffer (BTB) and a table of 2-bit saturating counters, and drives the predicted-taken bit and the target PC into fetch and the IF/ID pipeline register. It receives branch resolution from the execute stage, updates its tables, and raises the misprediction redirect and the flush requests for the Decode and Execute pipeline registers.

## Interface
- `IDX_W`, 6: index width; the BTB and the counter table each have 2^IDX_W entries.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `PCF` in 32: fetch PC.
- `BP` out 1: predicted taken for `PCF`; drives the IF/ID `BP` input.
- `PredPCF` out 32: predicted target; valid when `BP`=1.
- `BranchE` in 1: the execute-stage instruction is a conditional branch or JAL.
- `TakenE` in 1: resolved direction in execute.
- `BPE` in 1: prediction carried down the pipeline with the instruction.
- `StallE` in 1: execute stage is stalled; blocks the table update.
- `PCE`, `PCPlus4E`, `PCTargetE` in 32 each: execute PC, fall-through address, and resolved target.
- `MispredictE` out 1: fetch must be redirected.
- `RedirectPCE` out 32: corrected fetch PC.
- `FlushD`, `FlushE` out 1 each: clear requests for the IF/ID and ID/EX registers.

## Operation
- Index `idx` = `PCF[IDX_W+1:2]`, hashed as described under Configuration. Tag = `PCF[31:IDX_W+2]`.
- BTB entry fields: valid, tag, 32-bit target. Counter entry: 2 bits, where 00 is strongly not-taken and 11 is strongly taken.
- Lookup is combinational:
  - hit = valid && tag match.
  - `BP` = hit && counter[idx][1].
  - `PredPCF` = BTB target on a hit, otherwise 0.
- Resolution condition: `BranchE` && !`StallE`. When it holds, the following updates take effect at the next rising edge, using the index and tag recomputed from `PCE`:
  - The counter saturates up if `TakenE`, and saturates down otherwise.
  - If `TakenE`, the BTB entry is written with valid=1, the `PCE` tag, and `PCTargetE`. This write replaces any aliasing entry.
  - A not-taken resolution leaves the BTB entry unchanged.
- Misprediction is combinational and gated by !`StallE`:
  - `MispredictE` = (`BranchE` && (`BPE` xor `TakenE`)) || (!`BranchE` && `BPE`).
  - `RedirectPCE` = `PCTargetE` if (`BranchE` && `TakenE`), otherwise `PCPlus4E`.
  - `FlushD` = `FlushE` = `MispredictE`.
- JALR is never allocated in the BTB. Any BTB hit is therefore an exact-tag direct target, and the predicted target is always correct when the direction is correct.

## Timing
- Reset values:
  - all valid bits 0
  - all counters 01 (weakly not-taken)
  - history register 0
  - `BP`=0, `PredPCF`=0, `MispredictE`=0, `FlushD`=0, `FlushE`=0, `RedirectPCE`=`PCPlus4E`
- Lookup latency is zero cycles; `BP` and `PredPCF` are settled in the same cycle as `PCF`.
- Update latency is one edge. If a lookup and an update hit the same entry in the same cycle, the lookup sees the old contents, and the new contents are visible from the next cycle.
- Flush and redirect are asserted during the execute cycle. The IF/ID and ID/EX registers clear, and the PC loads `RedirectPCE`, at the following edge.
- While `StallE`=1, nothing updates and no flush is raised. The same instruction is resolved exactly once, on the cycle its stall releases.
- Reset asserted in mid-operation clears state immediately. Any update pending at that edge is discarded.

## Configuration
- `BP_GSHARE_EN` defined:
  - An IDX_W-bit global history register (GHR) is compiled in.
  - Counter index = `PCF[IDX_W+1:2]` xor GHR; update index = `PCE[IDX_W+1:2]` xor GHR.
  - On each resolution the GHR shifts left and inserts `TakenE`, non-speculatively.
  - The BTB stays indexed by the raw PC.
- `BP_GSHARE_EN` undefined:
  - No GHR exists; the predictor is plain bimodal.
  - The counter index equals the BTB index.

## Test plan
1. **Reset lookup:** reset, then `PCF`=0x100 → `BP`=0, `PredPCF`=0, `MispredictE`=0.
2. **First-time taken branch:** `BranchE`=1, `TakenE`=1, `BPE`=0, `PCE`=0x100, `PCTargetE`=0x80 → `MispredictE`=`FlushD`=`FlushE`=1 and `RedirectPCE`=0x80. On the next cycle `PCF`=0x100 gives `BP`=1 (counter 10) and `PredPCF`=0x80.
3. **Saturation:** resolve 0x100 taken four times, then not-taken once → `BP` stays 1 (11 goes to 10). A second not-taken → `BP`=0.
4. **Predicted taken, resolved not-taken:** `BPE`=1, `TakenE`=0, `PCPlus4E`=0x104 → `MispredictE`=1 and `RedirectPCE`=0x104.
5. **Stall and same-cycle collision:**
   - Hold `StallE`=1 for 3 cycles with a resolving branch → no flush and the counter is unchanged. Releasing the stall gives exactly one update.
   - With `PCF`=`PCE`=0x100 in the same cycle, `BP` shows the pre-update value.
6. **Aliasing:** 0x100 and 0x100+(4<<`IDX_W`), both taken, evict each other's BTB entry. A tag miss gives `BP`=0. Under `BP_GSHARE_EN`, check that the GHR changes the counter index.
